// File: rtl/id_table.sv
// Fully associative ID -> origin-port table with lowest-free allocation and round-robin eviction.
// Optional `full` occupancy output is built when ID_TABLE_FULL_FLAG_EN is defined.
module id_table #(
    parameter int unsigned NUMBER_OF_PORTS   = 2,
    parameter int unsigned ID_WIDTH          = 16,
    parameter int unsigned NUMBER_OF_ENTRIES = 32,
    localparam int unsigned OW = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ID_WIDTH-1:0] id,
    input  logic [OW-1:0]       origin,
    input  logic                insert,
    input  logic                lookup,
    input  logic                invalidate,
    output logic [OW-1:0]       answer,
    output logic                hit
`ifdef ID_TABLE_FULL_FLAG_EN
    ,
    output logic                full
`endif
);

    localparam int unsigned VW = $clog2(NUMBER_OF_ENTRIES);

    logic [NUMBER_OF_ENTRIES-1:0] valid_q;
    logic [ID_WIDTH-1:0]          id_q     [NUMBER_OF_ENTRIES];
    logic [OW-1:0]                origin_q [NUMBER_OF_ENTRIES];
    logic [VW-1:0]                victim_q;

    logic [NUMBER_OF_ENTRIES-1:0] match;
    logic                         match_any;
    logic [VW-1:0]                match_idx;
    logic [OW-1:0]                match_origin;
    logic                         free_any;
    logic [VW-1:0]                free_idx;
    logic [VW-1:0]                wr_idx;
    logic                         do_inv;
    logic                         do_ins;
    logic                         evict;

    // At most one entry can match, so OR-reducing the matching origins is exact.
    always_comb begin
        match        = '0;
        match_any    = 1'b0;
        match_idx    = '0;
        match_origin = '0;
        for (int i = 0; i < int'(NUMBER_OF_ENTRIES); i++) begin
            match[i] = valid_q[i] && (id_q[i] == id);
            if (match[i]) begin
                match_any    = 1'b1;
                match_idx    = VW'(i);
                match_origin = match_origin | origin_q[i];
            end
        end
    end

    // Scan downward so the lowest-index free entry wins.
    always_comb begin
        free_any = ~&valid_q;
        free_idx = '0;
        for (int i = int'(NUMBER_OF_ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = VW'(i);
            end
        end
    end

    always_comb begin
        do_inv = invalidate && match_any;
        do_ins = insert && !invalidate;
        evict  = do_ins && !match_any && !free_any;
        if (match_any) begin
            wr_idx = match_idx;
        end else if (free_any) begin
            wr_idx = free_idx;
        end else begin
            wr_idx = victim_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            victim_q <= '0;
        end else begin
            if (do_inv) begin
                valid_q[match_idx] <= 1'b0;
            end else if (do_ins) begin
                valid_q[wr_idx] <= 1'b1;
            end
            if (evict) begin
                victim_q <= (victim_q == VW'(NUMBER_OF_ENTRIES - 1)) ? '0 : victim_q + VW'(1);
            end
        end
    end

    // Payload storage carries no reset; validity alone gates its use.
    always_ff @(posedge clock) begin
        if (do_ins) begin
            id_q[wr_idx]     <= id;
            origin_q[wr_idx] <= origin;
        end
    end

    assign hit    = reset && lookup && match_any;
    assign answer = hit ? match_origin : '0;

`ifdef ID_TABLE_FULL_FLAG_EN
    assign full = &valid_q;
`endif

endmodule

// File: tb/tb_id_table.sv
// Self-checking bench for id_table: directed scenarios plus randomized traffic
// compared against a behavioural table model.
module tb_id_table;

    localparam int N = 32;

    logic        clock;
    logic        reset;
    logic [15:0] id;
    logic [0:0]  origin;
    logic        insert;
    logic        lookup;
    logic        invalidate;
    logic [0:0]  answer;
    logic        hit;
`ifdef ID_TABLE_FULL_FLAG_EN
    logic        full;
`endif

    id_table dut (
        .clock      (clock),
        .reset      (reset),
        .id         (id),
        .origin     (origin),
        .insert     (insert),
        .lookup     (lookup),
        .invalidate (invalidate),
        .answer     (answer),
        .hit        (hit)
`ifdef ID_TABLE_FULL_FLAG_EN
        ,
        .full       (full)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: a list of slots, each either empty or holding (id, origin).
    bit       m_valid [N];
    int       m_id    [N];
    int       m_org   [N];
    int       m_victim;

    logic     got_hit;
    logic     got_ans;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int m_find(input int key);
        for (int i = 0; i < N; i++) if (m_valid[i] && m_id[i] == key) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_victim = 0;
    endfunction

    function automatic void m_apply(input bit ins, input bit inv, input int key, input int org);
        int idx;
        idx = m_find(key);
        if (inv) begin
            if (idx >= 0) m_valid[idx] = 0;
        end else if (ins) begin
            if (idx >= 0) begin
                m_org[idx] = org;
            end else if (m_count() < N) begin
                for (int i = 0; i < N; i++) begin
                    if (!m_valid[i]) begin
                        m_valid[i] = 1; m_id[i] = key; m_org[i] = org;
                        break;
                    end
                end
            end else begin
                m_id[m_victim]  = key;
                m_org[m_victim] = org;
                m_victim        = (m_victim + 1) % N;
            end
        end
    endfunction

    // One clock of stimulus; outputs sampled mid-low-phase against pre-update model state.
    task automatic do_cycle(input bit ins, input bit lkp, input bit inv,
                            input int key, input int org);
        int idx;
        @(negedge clock);
        insert     = ins;
        lookup     = lkp;
        invalidate = inv;
        id         = key[15:0];
        origin     = org[0:0];
        #2;
        got_hit = hit;
        got_ans = answer;
        idx = m_find(key);
        if (lkp) begin
            check("model_hit", {31'b0, hit}, (idx >= 0) ? 32'd1 : 32'd0);
            check("model_answer", {31'b0, answer}, (idx >= 0) ? m_org[idx] : 0);
        end else begin
            check("idle_hit", {31'b0, hit}, 32'd0);
        end
`ifdef ID_TABLE_FULL_FLAG_EN
        check("model_full", {31'b0, full}, (m_count() == N) ? 32'd1 : 32'd0);
`endif
        m_apply(ins, inv, key, org);
    endtask

    task automatic do_lookup(input string tag, input int key, input bit exp_hit, input bit exp_ans);
        do_cycle(0, 1, 0, key, 0);
        check({tag, "_hit"}, {31'b0, got_hit}, {31'b0, exp_hit});
        check({tag, "_ans"}, {31'b0, got_ans}, {31'b0, exp_ans});
    endtask

    task automatic clear_inputs();
        insert = 0; lookup = 0; invalidate = 0; id = '0; origin = '0;
    endtask

    initial begin
        int key;
        bit ins, lkp, inv;
        clear_inputs();
        m_clear();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        lookup = 1; id = 16'h0001;
        #1;
        check("reset_hit", {31'b0, hit}, 32'd0);
        check("reset_answer", {31'b0, answer}, 32'd0);
        @(negedge clock);
        clear_inputs();
        reset = 1'b1;

        do_lookup("r028", 16'h0001, 0, 0);

        for (int k = 0; k < 4; k++) do_cycle(1, 0, 0, 16'h018d + k * 16'h0020, 1);
        do_lookup("r029a", 16'h01ad, 1, 1);
        do_lookup("r029b", 16'h01ed, 1, 1);
        do_lookup("r029c", 16'h090d, 0, 0);

        for (int k = 4; k < 32; k++) do_cycle(1, 0, 0, 16'h018d + k * 16'h0020, k & 1);
`ifdef ID_TABLE_FULL_FLAG_EN
        #1 check("r030_full_before", {31'b0, full}, 32'd1);
`endif
        do_cycle(0, 0, 1, 16'h01ad, 0);
        do_lookup("r030a", 16'h01ad, 0, 0);
        do_lookup("r030b", 16'h018d, 1, 1);
`ifdef ID_TABLE_FULL_FLAG_EN
        check("r030_full_after", {31'b0, full}, 32'd0);
`endif

        // Refill the freed slot so the table is full again, then force an eviction of slot 0.
        do_cycle(1, 0, 0, 16'h01ad, 1);
        do_cycle(1, 0, 0, 16'h1234, 0);
        do_lookup("r031a", 16'h018d, 0, 0);
        do_lookup("r031b", 16'h1234, 1, 0);

        do_cycle(1, 0, 0, 16'h0042, 0);
        do_cycle(1, 0, 0, 16'h0042, 1);
        do_lookup("r032a", 16'h0042, 1, 1);
        do_cycle(0, 0, 1, 16'h0042, 0);
        do_lookup("r032b", 16'h0042, 0, 0);

        // Lookup sees pre-update contents; insert loses to a same-cycle invalidate.
        do_cycle(0, 1, 1, 16'h1234, 0);
        check("same_cycle_inv_hit", {31'b0, got_hit}, 32'd1);
        do_lookup("after_inv", 16'h1234, 0, 0);
        do_cycle(1, 0, 1, 16'h0777, 1);
        do_lookup("ins_inv_conflict", 16'h0777, 0, 0);

        @(negedge clock);
        reset = 1'b0;
        lookup = 1; id = 16'h020d;
        #2;
        check("mid_reset_hit", {31'b0, hit}, 32'd0);
        check("mid_reset_answer", {31'b0, answer}, 32'd0);
        @(negedge clock);
        clear_inputs();
        reset = 1'b1;
        m_clear();
        for (int k = 0; k < 32; k++) do_lookup("post_reset", 16'h018d + k * 16'h0020, 0, 0);

        // Random traffic over a small key pool so the table fills and evicts.
        for (int c = 0; c < 1500; c++) begin
            key = 16'h0100 + $urandom_range(0, 47);
            ins = ($urandom_range(0, 99) < 50);
            inv = ($urandom_range(0, 99) < 15);
            lkp = ($urandom_range(0, 99) < 70);
            do_cycle(ins, lkp, inv, key, $urandom_range(0, 1));
        end

        @(negedge clock);
        clear_inputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
